bsg_fifo_1r1w_credit_batched: RTL and testbench
===============================================

# bsg_fifo_1r1w_credit_batched

Parametrised credit-flow FIFO with batched credit return. It sits on the receive side of a credit link, between a remote sender that holds `els_p` initial credits and a local valid/yumi consumer. Unlike a one-credit-per-dequeue design, it accumulates dequeues and returns them as a single counted credit pulse every `credit_batch_p` dequeues, or on demand via `flush_i`. This reduces credit-wire activity on long links.

## Interface
- `width_p`, default 128: data width in bits.
- `els_p`, default 16: FIFO depth; equals the sender's initial credit count; must be ≥ 2.
- `credit_batch_p`, default 4: dequeues per credit return; 1 ≤ `credit_batch_p` ≤ `els_p`.
- `cnt_width_lp`, derived as `$clog2(credit_batch_p+1)`: width of `credit_cnt_o`.
- `clk_i` — in — 1 — single clock; all state updates on the rising edge.
- `reset_i` — in — 1 — asynchronous, active-high reset.
- `data_i` — in — `width_p` — enqueue data.
- `v_i` — in — 1 — enqueue strobe. There is no ready; the sender may assert it only while holding a credit.
- `v_o` — out — 1 — head of FIFO is valid.
- `data_o` — out — `width_p` — head data, combinational from storage.
- `yumi_i` — in — 1 — consumer dequeues the head; legal only while `v_o` is high.
- `flush_i` — in — 1 — return all pending credits now.
- `credit_o` — out — 1 — registered credit-return pulse.
- `credit_cnt_o` — out — `cnt_width_lp` — credits returned with this pulse; 0 whenever `credit_o` is low.
- `error_o` — out — 1 — sticky overflow/protocol error flag; see Configuration.

## Operation
- **Storage:** `els_p`-entry circular buffer with `wr_ptr_r` and `rd_ptr_r`, each `$clog2(els_p)` bits, plus an occupancy counter `count_r` from 0 to `els_p`.
- **Pointer wrap:** each pointer wraps from `els_p-1` to 0. `els_p` need not be a power of two, so wrap uses an explicit compare, not natural overflow.
- **Enqueue:** `v_i` writes `data_i` at `wr_ptr_r` and advances it.
- **Dequeue:** `yumi_i` advances `rd_ptr_r`. `v_o` = (`count_r` != 0).
- **Simultaneous enqueue and dequeue:** `count_r` is unchanged. This is legal even at `count_r == els_p`, because the freed slot is written at the same edge it is read.
- **Overflow:** `v_i` with `count_r == els_p` and no `yumi_i`. The write is dropped and the pointers and count hold.
- **Underflow:** `yumi_i` with `count_r == 0`. It is ignored.
- **Credit accumulator:** `pend_r` runs from 0 to `credit_batch_p-1`. Per cycle, let sum = `pend_r` + `yumi_i`.
  - If sum == `credit_batch_p`: `credit_o` ← 1, `credit_cnt_o` ← `credit_batch_p`, `pend_r` ← 0.
  - Else if `flush_i` and sum > 0: `credit_o` ← 1, `credit_cnt_o` ← sum, `pend_r` ← 0.
  - Else: `credit_o` ← 0, `credit_cnt_o` ← 0, `pend_r` ← sum.
- **Flush with nothing pending:** `flush_i` with sum == 0 produces no pulse.
- **Credit conservation:** credits returned plus `pend_r` plus `count_r` always equals the total number of writes accepted.

## Timing
- **Reset values:** on `reset_i` assertion (asynchronous), every register clears immediately: pointers, `count_r`, `pend_r`, `credit_o`, `credit_cnt_o` and `error_o`. `v_o` reads 0.
- **Mid-operation reset:** all queued data and pending credits are discarded. The sender must also reset its credit counter.
- **Enqueue-to-output latency:** 1 cycle. A write at edge N gives `v_o` high after edge N with `data_o` equal to the written data. There is no bypass.
- **Credit latency:** `credit_o` rises in the cycle after the edge that captures the completing `yumi_i` or the `flush_i`. It is high for exactly one cycle per return.
- **Back-to-back returns:** supported with `credit_batch_p == 1`, giving one pulse per cycle.
- **Batching deadlock:** with `credit_batch_p > 1`, the sender can stall with credits stuck in `pend_r`. The integrator must drive `flush_i` periodically or when idle.

## Configuration
- **Macro:** `BSG_FIFO_CREDIT_CHECK_EN`.
- **When defined:**
  - `error_o` is set by an overflow or underflow event and held until reset.
  - A simulation `$error` fires on the same event.
  - An assertion checks credit conservation every cycle.
- **When undefined:** `error_o` is tied to 0, and the check logic and assertions are not compiled.
- **Both builds:** datapath behaviour is identical, including the dropped write on overflow.

## Structure
- **Shared package `bsg_fifo_credit_pkg`:** function `credit_cnt_width(batch)` and a localparam for the maximum supported batch size, 256.
- **Sub-module `bsg_credit_batcher`:** holds `pend_r`, the flush logic and the registered `credit_o`/`credit_cnt_o`. Ports: `clk_i`, `reset_i`, `yumi_i`, `flush_i`, `credit_o`, `credit_cnt_o`. It is reusable by other credit receivers.
- **Top level:** contains the storage, the pointers, `count_r` and the error logic.

## Test plan
- **Reset and fill:** `els_p`=16, `credit_batch_p`=4. Reset, then write 16 words 0..15 with no yumi → `v_o`=1, `data_o`=0, `credit_o` never pulses, `error_o`=0.
- **Drain in batches:** dequeue 8 words back-to-back → `credit_o` pulses with `credit_cnt_o`=4 in the cycle after the 4th yumi and again after the 8th; `data_o` sequence is 0..7.
- **Flush partial:** 3 yumis then `flush_i` → one pulse with `credit_cnt_o`=3. A yumi in the same cycle as `flush_i` gives `credit_cnt_o`=4. `flush_i` alone with `pend_r`=0 gives no pulse.
- **Full simultaneous:** with `count_r`=16, assert `v_i` and `yumi_i` together → no error, count stays 16, the new word appears 16 dequeues later. Also test `els_p`=5 to exercise non-power-of-two wrap.
- **Overflow:** `v_i` at full without yumi → write dropped. With `BSG_FIFO_CREDIT_CHECK_EN`, `error_o`=1 and sticky; without it, `error_o`=0.
- **Async reset:** assert `reset_i` mid-batch, between clock edges → all outputs go to 0 immediately, and the next batch counts from 0.

Source files
------------

// File: rtl/bsg_fifo_credit_pkg.sv
// Shared helpers for credit-returning FIFOs: counter sizing and the batch size limit.
package bsg_fifo_credit_pkg;

    localparam int max_credit_batch_lp = 256;

    function automatic int credit_cnt_width(input int batch);
        return $clog2(batch + 1);
    endfunction

endpackage

// File: rtl/bsg_credit_batcher.sv
// Gathers dequeues into one counted credit pulse every credit_batch_p dequeues, or
// sooner on flush. Reusable by any credit receiver.
module bsg_credit_batcher
    import bsg_fifo_credit_pkg::*;
#(
    parameter int credit_batch_p = 4,
    localparam int cnt_width_lp = credit_cnt_width(credit_batch_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    yumi_i,
    input  logic                    flush_i,
    output logic                    credit_o,
    output logic [cnt_width_lp-1:0] credit_cnt_o
);

    logic [cnt_width_lp-1:0] pend_q, pend_d;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic                    credit_q, credit_d;
    logic [cnt_width_lp-1:0] sum;

    // pend_q stays below credit_batch_p, so the sum never exceeds credit_batch_p
    assign sum = pend_q + cnt_width_lp'(yumi_i);

    always_comb begin
        credit_d = 1'b0;
        cnt_d    = '0;
        pend_d   = sum;
        if (sum == cnt_width_lp'(credit_batch_p)) begin
            credit_d = 1'b1;
            cnt_d    = sum;
            pend_d   = '0;
        end else if (flush_i && (sum != '0)) begin
            credit_d = 1'b1;
            cnt_d    = sum;
            pend_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pend_q   <= '0;
            cnt_q    <= '0;
            credit_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
        end
    end

    assign credit_o     = credit_q;
    assign credit_cnt_o = cnt_q;

endmodule

// File: rtl/bsg_fifo_1r1w_credit_batched.sv
// Receive-side credit FIFO with batched credit return. Optional overflow/underflow
// checking and credit-conservation assertion under BSG_FIFO_CREDIT_CHECK_EN.
module bsg_fifo_1r1w_credit_batched
    import bsg_fifo_credit_pkg::*;
#(
    parameter int width_p = 128,
    parameter int els_p = 16,
    parameter int credit_batch_p = 4,
    localparam int cnt_width_lp = credit_cnt_width(credit_batch_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [width_p-1:0]      data_i,
    input  logic                    v_i,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    yumi_i,
    input  logic                    flush_i,
    output logic                    credit_o,
    output logic [cnt_width_lp-1:0] credit_cnt_o,
    output logic                    error_o
);

    localparam int ptr_width_lp   = $clog2(els_p);
    localparam int count_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]        mem_q [els_p];
    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic                      full, empty, enq, deq;

    // Depth need not be a power of two, so wrap is an explicit compare
    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == count_width_lp'(els_p));
    assign empty = (count_q == '0);
    assign deq   = yumi_i & ~empty;
    assign enq   = v_i & (~full | deq);

    always_comb begin
        wr_ptr_d = enq ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = deq ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= data_i;
    end

    assign v_o    = ~empty;
    assign data_o = mem_q[rd_ptr_q];

    bsg_credit_batcher #(.credit_batch_p(credit_batch_p)) u_batcher (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .yumi_i       (deq),
        .flush_i      (flush_i),
        .credit_o     (credit_o),
        .credit_cnt_o (credit_cnt_o)
    );

`ifdef BSG_FIFO_CREDIT_CHECK_EN
    logic        error_q, ovf, unf;
    int unsigned accepted_q, returned_q;

    assign ovf = v_i & full & ~yumi_i;
    assign unf = yumi_i & empty;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_q    <= 1'b0;
            accepted_q <= 0;
            returned_q <= 0;
        end else begin
            error_q    <= error_q | ovf | unf;
            accepted_q <= accepted_q + 32'(enq);
            returned_q <= returned_q + 32'(credit_cnt_o);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && (ovf || unf))
            $error("credit fifo protocol error: overflow=%0b underflow=%0b", ovf, unf);
        // The pulse currently on credit_cnt_o already counts as returned
        if (!reset_i)
            assert (accepted_q == returned_q + 32'(credit_cnt_o)
                    + 32'(u_batcher.pend_q) + 32'(count_q))
            else $error("credit conservation violated");
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_credit_batched.sv
// Self-checking bench: two instances (16 deep / batch 4 and 5 deep / batch 3) against a
// queue-based reference model, with directed scenarios followed by random traffic.
module tb_bsg_fifo_1r1w_credit_batched;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] din;
    logic        v_d [2];
    logic        yumi_d [2];
    logic        flush_d [2];

    logic        v_o_w [2];
    logic [31:0] data_w [2];
    logic        credit_w [2];
    logic        err_w [2];
    logic [2:0]  cnt0;
    logic [1:0]  cnt1;

    int n_checks = 0;
    int n_bad = 0;

    int          els_m [2]   = '{16, 5};
    int          batch_m [2] = '{4, 3};
    logic [31:0] mq [2][$];
    int          pend_m [2];
    int          exp_credit [2];
    int          exp_cnt [2];
    int          err_m [2];

    always #5 clk = ~clk;

    bsg_fifo_1r1w_credit_batched #(.width_p(32), .els_p(16), .credit_batch_p(4)) dut0 (
        .clk_i(clk), .reset_i(reset_i), .data_i(din), .v_i(v_d[0]),
        .v_o(v_o_w[0]), .data_o(data_w[0]), .yumi_i(yumi_d[0]), .flush_i(flush_d[0]),
        .credit_o(credit_w[0]), .credit_cnt_o(cnt0), .error_o(err_w[0])
    );

    bsg_fifo_1r1w_credit_batched #(.width_p(32), .els_p(5), .credit_batch_p(3)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .data_i(din), .v_i(v_d[1]),
        .v_o(v_o_w[1]), .data_o(data_w[1]), .yumi_i(yumi_d[1]), .flush_i(flush_d[1]),
        .credit_o(credit_w[1]), .credit_cnt_o(cnt1), .error_o(err_w[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            pend_m[k] = 0;
            exp_credit[k] = 0;
            exp_cnt[k] = 0;
            err_m[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int n, sum;
        bit deq, enq;
        n   = mq[k].size();
        deq = yumi_d[k] && (n > 0);
        enq = v_d[k] && ((n < els_m[k]) || deq);
`ifdef BSG_FIFO_CREDIT_CHECK_EN
        if ((v_d[k] && n == els_m[k] && !yumi_d[k]) || (yumi_d[k] && n == 0)) err_m[k] = 1;
`endif
        if (deq) void'(mq[k].pop_front());
        if (enq) mq[k].push_back(din);
        sum = pend_m[k] + int'(deq);
        if (sum == batch_m[k]) begin
            exp_credit[k] = 1; exp_cnt[k] = sum; pend_m[k] = 0;
        end else if (flush_d[k] && sum > 0) begin
            exp_credit[k] = 1; exp_cnt[k] = sum; pend_m[k] = 0;
        end else begin
            exp_credit[k] = 0; exp_cnt[k] = 0; pend_m[k] = sum;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("d%0d.v_o", k), 32'(v_o_w[k]), 32'(mq[k].size() > 0));
            if (mq[k].size() > 0)
                check_val($sformatf("d%0d.data_o", k), data_w[k], mq[k][0]);
            check_val($sformatf("d%0d.credit_o", k), 32'(credit_w[k]), 32'(exp_credit[k]));
            check_val($sformatf("d%0d.credit_cnt_o", k),
                      (k == 0) ? 32'(cnt0) : 32'(cnt1), 32'(exp_cnt[k]));
            check_val($sformatf("d%0d.error_o", k), 32'(err_w[k]), 32'(err_m[k]));
        end
    endtask

    task automatic step();
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Directed traffic on the 16-deep instance; the 5-deep one idles
    task automatic drive0(input bit v, input bit y, input bit f, input logic [31:0] d);
        v_d[0] = v; yumi_d[0] = y; flush_d[0] = f;
        v_d[1] = 1'b0; yumi_d[1] = 1'b0; flush_d[1] = 1'b0;
        din = d;
        step();
    endtask

    initial begin
        reset_i = 1'b1;
        din = '0;
        for (int k = 0; k < 2; k++) begin
            v_d[k] = 1'b0; yumi_d[k] = 1'b0; flush_d[k] = 1'b0;
        end
        model_reset();
        @(negedge clk);
        check_all();
        reset_i = 1'b0;

        for (int i = 0; i < 16; i++) drive0(1, 0, 0, 32'(i));
        for (int i = 0; i < 8; i++) drive0(0, 1, 0, '0);

        for (int i = 0; i < 3; i++) drive0(0, 1, 0, '0);
        drive0(0, 0, 1, '0);
        for (int i = 0; i < 3; i++) drive0(0, 1, 0, '0);
        drive0(0, 1, 1, '0);
        drive0(0, 0, 1, '0);
        drive0(0, 0, 0, '0);

        for (int i = 0; i < 15; i++) drive0(1, 0, 0, 32'h100 + 32'(i));
        for (int i = 0; i < 3; i++) drive0(1, 1, 0, 32'h200 + 32'(i));
        drive0(1, 0, 0, 32'hdead);
        drive0(1, 0, 0, 32'hbeef);
        for (int i = 0; i < 16; i++) drive0(0, 1, 0, '0);
        drive0(0, 0, 1, '0);

        for (int i = 0; i < 4; i++) drive0(1, 0, 0, 32'h300 + 32'(i));
        for (int i = 0; i < 2; i++) drive0(0, 1, 0, '0);
        #2 reset_i = 1'b1;
        #1 model_reset();
        check_all();
        #1 reset_i = 1'b0;
        for (int i = 0; i < 4; i++) drive0(1, 0, 0, 32'h400 + 32'(i));
        for (int i = 0; i < 4; i++) drive0(0, 1, 0, '0);

        for (int c = 0; c < 2000; c++) begin
            din = $urandom;
            for (int k = 0; k < 2; k++) begin
                v_d[k]     = ($urandom_range(0, 3) != 0);
                yumi_d[k]  = (mq[k].size() > 0) && ($urandom_range(0, 1) == 1);
                flush_d[k] = ($urandom_range(0, 7) == 0);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
